dcache_mshr_file: RTL



---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_mshr_entry.sv | 126 ++++++++++++
 rtl/dcache_mshr_file.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the dcache miss-status holding register file.
// Entry lifecycle: FREE -> PEND -> WAIT -> REPLAY -> FREE.
package dcache_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    PEND   = 2'd1,
    WAIT   = 2'd2,
    REPLAY = 2'd3
  } mshr_state_e;

  function automatic logic mshr_live(mshr_state_e s);
    return s != FREE;
  endfunction

endpackage

// File: rtl/dcache_mshr_entry.sv
// One MSHR entry: state register, line/way record, load wait list and line compares.
// The entry state is visible on state_o for observation and checking.
module dcache_mshr_entry
  import dcache_pkg::*;
#(
  parameter int PLEN              = 32,
  parameter int LINE_OFFSET_WIDTH = 5,
  parameter int WAY_WIDTH         = 2,
  parameter int N_WAIT            = 4,
  parameter int LD_ID_WIDTH       = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              alloc_new_i,
  input  logic                              alloc_merge_i,
  input  logic                              alloc_is_load_i,
  input  logic [LD_ID_WIDTH-1:0]            alloc_ld_id_i,
  input  logic [PLEN-LINE_OFFSET_WIDTH-1:0] alloc_line_i,
  input  logic [WAY_WIDTH-1:0]              alloc_way_i,
  input  logic                              req_fire_i,
  input  logic                              refill_valid_i,
  input  logic [PLEN-LINE_OFFSET_WIDTH-1:0] refill_line_i,
  input  logic                              replay_fire_i,
  input  logic [PLEN-LINE_OFFSET_WIDTH-1:0] probe_line_i,
  output mshr_state_e                       state_o,
  output logic [PLEN-LINE_OFFSET_WIDTH-1:0] line_o,
  output logic [WAY_WIDTH-1:0]              way_o,
  output logic                              alloc_match_o,
  output logic                              probe_match_o,
  output logic                              refill_hit_o,
  output logic                              wl_full_o,
  output logic                              replay_pend_o,
  output logic [LD_ID_WIDTH-1:0]            head_id_o
);

  localparam int LINE_W = PLEN - LINE_OFFSET_WIDTH;
  localparam int CNT_W  = $clog2(N_WAIT + 1);

  typedef struct packed {
    mshr_state_e                         state;
    logic [LINE_W-1:0]                   line;
    logic [WAY_WIDTH-1:0]                way;
    logic [CNT_W-1:0]                    count;
    logic [CNT_W-1:0]                    rd_ptr;
    logic [N_WAIT-1:0][LD_ID_WIDTH-1:0]  ids;
  } mshr_entry_t;

  mshr_entry_t q, d;

  assign state_o       = q.state;
  assign line_o        = q.line;
  assign way_o         = q.way;
  assign alloc_match_o = mshr_live(q.state) && (q.line == alloc_line_i);
  assign probe_match_o = mshr_live(q.state) && (q.line == probe_line_i);
  assign refill_hit_o  = refill_valid_i && (q.state == WAIT) && (q.line == refill_line_i);
  assign wl_full_o     = (q.count == CNT_W'(N_WAIT));
  assign replay_pend_o = (q.state == REPLAY) && (q.rd_ptr < q.count);

  always_comb begin
    head_id_o = '0;
    for (int k = 0; k < N_WAIT; k++) begin
      if (CNT_W'(k) == q.rd_ptr) head_id_o = q.ids[k];
    end
  end

  always_comb begin
    d = q;
    if (flush_i) begin
      // A WAIT entry keeps its line so the outstanding refill is still absorbed.
      case (q.state)
        PEND, REPLAY: d.state = FREE;
        WAIT: begin
          d.count = '0;
          if (refill_hit_o) begin
            d.state  = REPLAY;
            d.rd_ptr = '0;
          end
        end
        default: ;
      endcase
    end else begin
      case (q.state)
        FREE: begin
          if (alloc_new_i) begin
            d.state  = PEND;
            d.line   = alloc_line_i;
            d.way    = alloc_way_i;
            d.rd_ptr = '0;
            d.ids    = '0;
            d.count  = alloc_is_load_i ? CNT_W'(1) : '0;
            d.ids[0] = alloc_ld_id_i;
          end
        end
        PEND, WAIT: begin
          if (alloc_merge_i && alloc_is_load_i) begin
            for (int k = 0; k < N_WAIT; k++) begin
              if (CNT_W'(k) == q.count) d.ids[k] = alloc_ld_id_i;
            end
            d.count = q.count + 1'b1;
          end
          if ((q.state == PEND) && req_fire_i) d.state = WAIT;
          if (refill_hit_o) begin
            d.state  = REPLAY;
            d.rd_ptr = '0;
          end
        end
        REPLAY: begin
          if (q.count == '0) begin
            d.state = FREE;
          end else if (replay_fire_i) begin
            if (q.rd_ptr == q.count - 1'b1) d.state = FREE;
            else d.rd_ptr = q.rd_ptr + 1'b1;
          end
        end
        default: d.state = FREE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q <= '0;
    else q <= d;
  end

endmodule

// File: rtl/dcache_mshr_file.sv
// N_MSHR-entry miss tracker with per-entry load wait lists and in-order replay by ID.
// Secondary-miss merging is enabled by defining DCACHE_MSHR_MERGE_EN; otherwise one load per entry.
module dcache_mshr_file
  import dcache_pkg::*;
#(
  parameter int PLEN              = 32,
  parameter int LINE_OFFSET_WIDTH = 5,
  parameter int INDEX_WIDTH       = 7,
  parameter int WAY_WIDTH         = 2,
  parameter int N_MSHR            = 4,
  parameter int N_WAIT            = 4,
  parameter int LD_ID_WIDTH       = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   alloc_valid_i,
  output logic                   alloc_ready_o,
  input  logic [PLEN-1:0]        alloc_paddr_i,
  input  logic [WAY_WIDTH-1:0]   alloc_way_i,
  input  logic                   alloc_is_load_i,
  input  logic [LD_ID_WIDTH-1:0] alloc_ld_id_i,
  output logic                   miss_req_valid_o,
  input  logic                   miss_req_ready_i,
  output logic [PLEN-1:0]        miss_req_paddr_o,
  output logic [WAY_WIDTH-1:0]   miss_req_victim_way_o,
  output logic [INDEX_WIDTH-1:0] miss_req_index_o,
  input  logic                   refill_valid_i,
  output logic                   refill_ready_o,
  input  logic [PLEN-1:0]        refill_paddr_i,
  output logic                   replay_valid_o,
  input  logic                   replay_ready_i,
  output logic [LD_ID_WIDTH-1:0] replay_ld_id_o,
  output logic [PLEN-1:0]        replay_paddr_o,
  input  logic [PLEN-1:0]        probe_paddr_i,
  output logic                   probe_hit_o,
  output logic                   full_o,
  output logic                   busy_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a producer holding valid keeps its payload stable until that edge.

  localparam int LINE_W = PLEN - LINE_OFFSET_WIDTH;
  localparam int IDX_W  = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
`ifdef DCACHE_MSHR_MERGE_EN
  localparam int WL_DEPTH = N_WAIT;
`else
  localparam int WL_DEPTH = 1;
  localparam int unused_n_wait = N_WAIT;
`endif

  logic [LINE_W-1:0]      alloc_line, refill_line, probe_line;
  mshr_state_e            ent_state   [N_MSHR];
  logic [LINE_W-1:0]      ent_line    [N_MSHR];
  logic [WAY_WIDTH-1:0]   ent_way     [N_MSHR];
  logic [LD_ID_WIDTH-1:0] ent_head_id [N_MSHR];
  logic [N_MSHR-1:0]      ent_alloc_match, ent_probe_match, ent_refill_hit;
  logic [N_MSHR-1:0]      ent_wl_full, ent_replay_pend, ent_live;
  logic [N_MSHR-1:0]      alloc_new, alloc_merge, req_fire, replay_fire;

  logic                   free_found, match_found, pend_found, rep_found;
  logic [IDX_W-1:0]       free_idx, match_idx, pend_idx, rep_sel;
  logic                   req_lock_q, rep_lock_q;
  logic [IDX_W-1:0]       req_idx_q, rep_idx_q, req_idx, rep_idx;
  logic                   req_valid, rep_valid, alloc_fire;

  assign alloc_line  = alloc_paddr_i[PLEN-1:LINE_OFFSET_WIDTH];
  assign refill_line = refill_paddr_i[PLEN-1:LINE_OFFSET_WIDTH];
  assign probe_line  = probe_paddr_i[PLEN-1:LINE_OFFSET_WIDTH];

  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    pend_found  = 1'b0;
    pend_idx    = '0;
    rep_found   = 1'b0;
    rep_sel     = '0;
    for (int i = 0; i < N_MSHR; i++) begin
      ent_live[i] = mshr_live(ent_state[i]);
      if (!free_found && !ent_live[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (!match_found && ent_alloc_match[i]) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!pend_found && (ent_state[i] == PEND)) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
      if (!rep_found && ent_replay_pend[i]) begin
        rep_found = 1'b1;
        rep_sel   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    alloc_ready_o = 1'b0;
    if (!flush_i) begin
      if (!match_found) begin
        alloc_ready_o = free_found;
      end else begin
`ifdef DCACHE_MSHR_MERGE_EN
        case (ent_state[match_idx])
          PEND: alloc_ready_o = !(alloc_is_load_i && ent_wl_full[match_idx]);
          WAIT: alloc_ready_o = !(alloc_is_load_i && ent_wl_full[match_idx]) &&
                                !ent_refill_hit[match_idx];
          default: alloc_ready_o = 1'b0;
        endcase
`else
        alloc_ready_o = 1'b0;
`endif
      end
    end
  end

  // Selection is frozen only while a valid output is stalled, keeping its payload stable.
  assign req_idx   = req_lock_q ? req_idx_q : pend_idx;
  assign req_valid = req_lock_q | pend_found;
  assign rep_idx   = rep_lock_q ? rep_idx_q : rep_sel;
  assign rep_valid = rep_lock_q | rep_found;
  assign alloc_fire = alloc_valid_i && alloc_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_lock_q <= 1'b0;
      rep_lock_q <= 1'b0;
      req_idx_q  <= '0;
      rep_idx_q  <= '0;
    end else begin
      req_lock_q <= req_valid && !miss_req_ready_i && !flush_i;
      rep_lock_q <= rep_valid && !replay_ready_i && !flush_i;
      req_idx_q  <= req_idx;
      rep_idx_q  <= rep_idx;
    end
  end

  always_comb begin
    for (int i = 0; i < N_MSHR; i++) begin
      alloc_new[i]   = alloc_fire && !match_found && (free_idx == IDX_W'(i));
      alloc_merge[i] = alloc_fire && match_found && (match_idx == IDX_W'(i));
      req_fire[i]    = req_valid && miss_req_ready_i && (req_idx == IDX_W'(i));
      replay_fire[i] = rep_valid && replay_ready_i && (rep_idx == IDX_W'(i));
    end
  end

  for (genvar g = 0; g < N_MSHR; g++) begin : g_entry
    dcache_mshr_entry #(
      .PLEN              (PLEN),
      .LINE_OFFSET_WIDTH (LINE_OFFSET_WIDTH),
      .WAY_WIDTH         (WAY_WIDTH),
      .N_WAIT            (WL_DEPTH),
      .LD_ID_WIDTH       (LD_ID_WIDTH)
    ) u_entry (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .alloc_new_i     (alloc_new[g]),
      .alloc_merge_i   (alloc_merge[g]),
      .alloc_is_load_i (alloc_is_load_i),
      .alloc_ld_id_i   (alloc_ld_id_i),
      .alloc_line_i    (alloc_line),
      .alloc_way_i     (alloc_way_i),
      .req_fire_i      (req_fire[g]),
      .refill_valid_i  (refill_valid_i),
      .refill_line_i   (refill_line),
      .replay_fire_i   (replay_fire[g]),
      .probe_line_i    (probe_line),
      .state_o         (ent_state[g]),
      .line_o          (ent_line[g]),
      .way_o           (ent_way[g]),
      .alloc_match_o   (ent_alloc_match[g]),
      .probe_match_o   (ent_probe_match[g]),
      .refill_hit_o    (ent_refill_hit[g]),
      .wl_full_o       (ent_wl_full[g]),
      .replay_pend_o   (ent_replay_pend[g]),
      .head_id_o       (ent_head_id[g])
    );
  end

  assign miss_req_valid_o      = req_valid;
  assign miss_req_paddr_o      = req_valid ? {ent_line[req_idx], {LINE_OFFSET_WIDTH{1'b0}}} : '0;
  assign miss_req_victim_way_o = req_valid ? ent_way[req_idx] : '0;
  assign miss_req_index_o      = req_valid ? ent_line[req_idx][INDEX_WIDTH-1:0] : '0;
  assign replay_valid_o        = rep_valid;
  assign replay_ld_id_o        = rep_valid ? ent_head_id[rep_idx] : '0;
  assign replay_paddr_o        = rep_valid ? {ent_line[rep_idx], {LINE_OFFSET_WIDTH{1'b0}}} : '0;
  assign refill_ready_o        = 1'b1;
  assign probe_hit_o           = |ent_probe_match;
  assign full_o                = !free_found;
  assign busy_o                = |ent_live;

  logic unused_bits;
`ifdef DCACHE_MSHR_MERGE_EN
  assign unused_bits = ^{alloc_paddr_i[LINE_OFFSET_WIDTH-1:0], refill_paddr_i[LINE_OFFSET_WIDTH-1:0],
                         probe_paddr_i[LINE_OFFSET_WIDTH-1:0]};
`else
  assign unused_bits = ^{alloc_paddr_i[LINE_OFFSET_WIDTH-1:0], refill_paddr_i[LINE_OFFSET_WIDTH-1:0],
                         probe_paddr_i[LINE_OFFSET_WIDTH-1:0], ent_wl_full, ent_refill_hit};
`endif

endmodule
